// File: rtl/mem_access_unit.sv
// MEM-stage load/store unit: request/handshake FSM, store lane replication and load alignment.
// Optional MEM_ALIGN_CHECK_EN: reject misaligned accesses with adel/ades instead of forcing alignment.
module mem_access_unit #(
   parameter int WIDTH = 32
) (
   input  logic             clk,
   input  logic             resetn,
   input  logic             in_valid,
   input  logic             mem_read,
   input  logic             mem_write,
   input  logic [1:0]       mem_size,
   input  logic             mem_signed,
   input  logic [WIDTH-1:0] addr,
   input  logic [WIDTH-1:0] store_data,
   input  logic             flush,
   input  logic             wb_ready,
   output logic             data_req,
   output logic             data_wr,
   output logic [1:0]       data_size,
   output logic [WIDTH-1:0] data_addr,
   output logic [WIDTH-1:0] data_wdata,
   output logic [3:0]       data_wstrb,
   input  logic             data_addr_ok,
   input  logic             data_data_ok,
   input  logic [WIDTH-1:0] data_rdata,
   output logic [WIDTH-1:0] Memdata,
   output logic             out_valid,
   output logic             stall,
   output logic             adel,
   output logic             ades
);

   typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

   state_t           state;
   logic             signed_p1;
   logic             discard_p1;
   logic             is_mem;
   logic             accept;
   logic             done;
   logic             kill;
   logic [WIDTH-1:0] eff_addr;
`ifdef MEM_ALIGN_CHECK_EN
   logic             misaligned;
`endif

   function automatic logic [WIDTH-1:0] lane_wdata(input logic [1:0] sz, input logic [WIDTH-1:0] sd);
      case (sz)
         2'b00:   return {(WIDTH/8){sd[7:0]}};
         2'b01:   return {(WIDTH/16){sd[15:0]}};
         default: return sd;
      endcase
   endfunction

   function automatic logic [3:0] lane_wstrb(input logic [1:0] sz, input logic [1:0] a, input logic wr);
      if (!wr) return 4'b0000;
      case (sz)
         2'b00:   return 4'b0001 << a;
         2'b01:   return 4'b0011 << a;
         default: return 4'b1111;
      endcase
   endfunction

   // Word accesses always arrive with a==0, so the shifted value is the raw word.
   function automatic logic [WIDTH-1:0] load_extract(input logic [WIDTH-1:0] rdata, input logic [1:0] a,
                                                     input logic [1:0] sz, input logic sg);
      logic [WIDTH-1:0] sh;
      sh = rdata >> {a, 3'b000};
      case (sz)
         2'b00:   return {{(WIDTH-8){sg & sh[7]}}, sh[7:0]};
         2'b01:   return {{(WIDTH-16){sg & sh[15]}}, sh[15:0]};
         default: return sh;
      endcase
   endfunction

   always_comb begin
      is_mem   = in_valid & (mem_read | mem_write);
      eff_addr = addr;
`ifdef MEM_ALIGN_CHECK_EN
      misaligned = ((mem_size == 2'b01) & addr[0]) | (mem_size[1] & (|addr[1:0]));
      accept     = (state == IDLE) & is_mem & !flush & !misaligned;
`else
      if (mem_size == 2'b01)
         eff_addr[0] = 1'b0;
      else if (mem_size[1])
         eff_addr[1:0] = 2'b00;
      accept = (state == IDLE) & is_mem & !flush;
`endif
      done  = ((state == REQ) & data_addr_ok & data_data_ok) | ((state == WAIT) & data_data_ok);
      kill  = discard_p1 | flush;
      stall = accept | (state == REQ) | (state == WAIT) | ((state == HOLD) & !wb_ready);
   end

   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state      <= IDLE;
         signed_p1  <= 1'b0;
         discard_p1 <= 1'b0;
         data_req   <= 1'b0;
         data_wr    <= 1'b0;
         data_size  <= 2'b00;
         data_addr  <= '0;
         data_wdata <= '0;
         data_wstrb <= 4'b0000;
         Memdata    <= '0;
         out_valid  <= 1'b0;
         adel       <= 1'b0;
         ades       <= 1'b0;
      end else begin
         adel <= 1'b0;
         ades <= 1'b0;
         case (state)
            IDLE: begin
               discard_p1 <= 1'b0;
               if (accept) begin
                  state      <= REQ;
                  data_req   <= 1'b1;
                  data_wr    <= mem_write;
                  data_size  <= mem_size;
                  data_addr  <= eff_addr;
                  signed_p1  <= mem_signed;
                  data_wdata <= lane_wdata(mem_size, store_data);
                  data_wstrb <= lane_wstrb(mem_size, eff_addr[1:0], mem_write);
               end
`ifdef MEM_ALIGN_CHECK_EN
               else if (is_mem & !flush & misaligned) begin
                  adel <= mem_read;
                  ades <= !mem_read;
               end
`endif
            end
            REQ, WAIT: begin
               if (flush)
                  discard_p1 <= 1'b1;
               if ((state == REQ) && data_addr_ok) begin
                  data_req <= 1'b0;
                  state    <= WAIT;
               end
               // Completion: a flushed access retires silently back to IDLE.
               if (done) begin
                  if (kill) begin
                     state <= IDLE;
                  end else begin
                     state     <= HOLD;
                     out_valid <= 1'b1;
                     if (!data_wr)
                        Memdata <= load_extract(data_rdata, data_addr[1:0], data_size, signed_p1);
                  end
               end
            end
            HOLD: begin
               if (wb_ready || flush) begin
                  state     <= IDLE;
                  out_valid <= 1'b0;
               end
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_access_unit.sv
// Directed testbench for mem_access_unit; honours MEM_ALIGN_CHECK_EN for the misaligned-access case.
module tb_mem_access_unit;

   logic        clk = 1'b0;
   logic        resetn = 1'b0;
   logic        in_valid = 1'b0, mem_read = 1'b0, mem_write = 1'b0, mem_signed = 1'b0;
   logic [1:0]  mem_size = 2'b00;
   logic [31:0] addr = '0, store_data = '0;
   logic        flush = 1'b0, wb_ready = 1'b0;
   logic        data_req, data_wr;
   logic [1:0]  data_size;
   logic [31:0] data_addr, data_wdata;
   logic [3:0]  data_wstrb;
   logic        data_addr_ok = 1'b0, data_data_ok = 1'b0;
   logic [31:0] data_rdata = '0;
   logic [31:0] Memdata;
   logic        out_valid, stall, adel, ades;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   mem_access_unit #(.WIDTH(32)) dut (
      .clk(clk), .resetn(resetn), .in_valid(in_valid), .mem_read(mem_read), .mem_write(mem_write),
      .mem_size(mem_size), .mem_signed(mem_signed), .addr(addr), .store_data(store_data),
      .flush(flush), .wb_ready(wb_ready), .data_req(data_req), .data_wr(data_wr),
      .data_size(data_size), .data_addr(data_addr), .data_wdata(data_wdata), .data_wstrb(data_wstrb),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .Memdata(Memdata), .out_valid(out_valid), .stall(stall), .adel(adel), .ades(ades)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // Called at a negedge: presents one instruction for a cycle, returns at the next negedge.
   task automatic issue(input logic rd, input logic wr, input logic [1:0] sz, input logic sg,
                        input logic [31:0] a, input logic [31:0] sd, input logic exp_stall, input string tag);
      in_valid = 1'b1; mem_read = rd; mem_write = wr; mem_size = sz; mem_signed = sg;
      addr = a; store_data = sd;
      #1 chk({tag, "_accept_stall"}, {31'b0, stall}, {31'b0, exp_stall});
      @(negedge clk);
      in_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0; flush = 1'b0;
   endtask

   initial begin
      // reset state
      @(negedge clk);
      chk("rst_data_req", {31'b0, data_req}, 32'd0);
      chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
      chk("rst_stall", {31'b0, stall}, 32'd0);
      chk("rst_memdata", Memdata, 32'd0);
      chk("rst_wstrb", {28'b0, data_wstrb}, 32'd0);
      chk("rst_adel_ades", {30'b0, adel, ades}, 32'd0);
      resetn = 1'b1;
      @(negedge clk);

      // LB signed at 0x1003, same-cycle addr_ok/data_ok
      issue(1, 0, 2'b00, 1, 32'h1003, 32'h0, 1, "lb");
      chk("lb_req", {31'b0, data_req}, 32'd1);
      chk("lb_addr", data_addr, 32'h1003);
      chk("lb_wstrb", {28'b0, data_wstrb}, 32'h0);
      chk("lb_outv_early", {31'b0, out_valid}, 32'd0);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80112233;
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      chk("lb_outv", {31'b0, out_valid}, 32'd1);
      chk("lb_memdata", Memdata, 32'hFFFFFF80);
      chk("lb_req_drop", {31'b0, data_req}, 32'd0);
      #1 chk("lb_hold_stall", {31'b0, stall}, 32'd1);
      wb_ready = 1'b1;
      #1 chk("lb_hold_ready_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      wb_ready = 1'b0;
      chk("lb_outv_gone", {31'b0, out_valid}, 32'd0);

      // SH store at 0x2002
      issue(0, 1, 2'b01, 0, 32'h2002, 32'h0000ABCD, 1, "sh");
      chk("sh_wdata", data_wdata, 32'hABCDABCD);
      chk("sh_wstrb", {28'b0, data_wstrb}, 32'hC);
      chk("sh_wr", {31'b0, data_wr}, 32'd1);
      chk("sh_size", {30'b0, data_size}, 32'd1);
      chk("sh_addr", data_addr, 32'h2002);
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      chk("sh_wait_req", {31'b0, data_req}, 32'd0);
      chk("sh_wait_stall", {31'b0, stall}, 32'd1);
      data_data_ok = 1'b1;
      @(negedge clk);
      data_data_ok = 1'b0;
      chk("sh_outv", {31'b0, out_valid}, 32'd1);
      chk("sh_memdata_kept", Memdata, 32'hFFFFFF80);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;

      // LW with addr_ok after 3 waiting cycles, data_ok 2 cycles later
      issue(1, 0, 2'b10, 0, 32'h4000, 32'h0, 1, "lw");
      for (int i = 0; i < 4; i++) begin
         chk($sformatf("lw_req_c%0d", i), {31'b0, data_req}, 32'd1);
         chk($sformatf("lw_addr_c%0d", i), data_addr, 32'h4000);
         chk($sformatf("lw_size_c%0d", i), {30'b0, data_size}, 32'd2);
         chk($sformatf("lw_stall_c%0d", i), {31'b0, stall}, 32'd1);
         if (i == 3) data_addr_ok = 1'b1;
         @(negedge clk);
      end
      data_addr_ok = 1'b0;
      chk("lw_wait1_stall", {31'b0, stall}, 32'd1);
      chk("lw_wait1_req", {31'b0, data_req}, 32'd0);
      @(negedge clk);
      chk("lw_wait2_stall", {31'b0, stall}, 32'd1);
      data_data_ok = 1'b1; data_rdata = 32'hDEADBEEF;
      @(negedge clk);
      data_data_ok = 1'b0;
      chk("lw_outv", {31'b0, out_valid}, 32'd1);
      chk("lw_memdata", Memdata, 32'hDEADBEEF);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;

      // LHU flushed in WAIT
      issue(1, 0, 2'b01, 0, 32'h5002, 32'h0, 1, "lhu");
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0; flush = 1'b1;
      @(negedge clk);
      flush = 1'b0; data_data_ok = 1'b1; data_rdata = 32'h12345678;
      chk("lhu_wait_stall", {31'b0, stall}, 32'd1);
      @(negedge clk);
      data_data_ok = 1'b0;
      chk("lhu_outv", {31'b0, out_valid}, 32'd0);
      chk("lhu_memdata", Memdata, 32'hDEADBEEF);
      chk("lhu_idle_stall", {31'b0, stall}, 32'd0);
      @(negedge clk);
      chk("lhu_outv_later", {31'b0, out_valid}, 32'd0);

      // flush in IDLE beats in_valid
      flush = 1'b1;
      issue(1, 0, 2'b10, 0, 32'h4000, 32'h0, 0, "idle_flush");
      chk("idle_flush_req", {31'b0, data_req}, 32'd0);

      // non-memory instruction
      issue(0, 0, 2'b10, 0, 32'h4000, 32'h0, 0, "nonmem");
      chk("nonmem_req", {31'b0, data_req}, 32'd0);
      chk("nonmem_outv", {31'b0, out_valid}, 32'd0);

      // SB at byte lane 1
      issue(0, 1, 2'b00, 0, 32'h0011, 32'h123456A5, 1, "sb");
      chk("sb_wdata", data_wdata, 32'hA5A5A5A5);
      chk("sb_wstrb", {28'b0, data_wstrb}, 32'h2);
      data_addr_ok = 1'b1; data_data_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0; wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;

      // LH signed upper half, then flush while holding
      issue(1, 0, 2'b01, 1, 32'h6002, 32'h0, 1, "lh");
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h80017FFF;
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      chk("lh_memdata", Memdata, 32'hFFFF8001);
      chk("lh_outv", {31'b0, out_valid}, 32'd1);
      flush = 1'b1;
      @(negedge clk);
      flush = 1'b0;
      chk("hold_flush_outv", {31'b0, out_valid}, 32'd0);

      // LW at misaligned 0x3001
`ifdef MEM_ALIGN_CHECK_EN
      issue(1, 0, 2'b10, 0, 32'h3001, 32'h0, 0, "mis");
      chk("mis_adel", {31'b0, adel}, 32'd1);
      chk("mis_ades", {31'b0, ades}, 32'd0);
      chk("mis_req", {31'b0, data_req}, 32'd0);
      @(negedge clk);
      chk("mis_adel_pulse", {31'b0, adel}, 32'd0);
      chk("mis_req_later", {31'b0, data_req}, 32'd0);
`else
      issue(1, 0, 2'b10, 0, 32'h3001, 32'h0, 1, "mis");
      chk("mis_req", {31'b0, data_req}, 32'd1);
      chk("mis_addr", data_addr, 32'h3000);
      chk("mis_adel", {31'b0, adel}, 32'd0);
      data_addr_ok = 1'b1; data_data_ok = 1'b1; data_rdata = 32'hCAFEF00D;
      @(negedge clk);
      data_addr_ok = 1'b0; data_data_ok = 1'b0;
      chk("mis_memdata", Memdata, 32'hCAFEF00D);
      wb_ready = 1'b1;
      @(negedge clk);
      wb_ready = 1'b0;
`endif

      // reset in WAIT, late data_ok ignored
      issue(1, 0, 2'b10, 0, 32'h7000, 32'h0, 1, "rstw");
      data_addr_ok = 1'b1;
      @(negedge clk);
      data_addr_ok = 1'b0;
      resetn = 1'b0;
      #1 chk("rstw_req", {31'b0, data_req}, 32'd0);
      chk("rstw_stall", {31'b0, stall}, 32'd0);
      chk("rstw_memdata", Memdata, 32'd0);
      @(negedge clk);
      resetn = 1'b1; data_data_ok = 1'b1; data_rdata = 32'h55555555;
      @(negedge clk);
      data_data_ok = 1'b0;
      chk("rstw_late_outv", {31'b0, out_valid}, 32'd0);
      chk("rstw_late_req", {31'b0, data_req}, 32'd0);
      chk("rstw_late_memdata", Memdata, 32'd0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/mem_access_unit.md
MEM_ACCESS_UNIT -- requirements
Module: mem_access_unit

Interface
REQ-001 Parameter WIDTH, default 32: width of the data path and the address.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 resetn  input  1  asynchronous, active-low reset.
REQ-004 in_valid  input  1  MEM-stage instruction valid.
REQ-005 mem_read  input  1  instruction is a load.
REQ-006 mem_write  input  1  instruction is a store.
REQ-007 mem_size  input  2  access size: 00 byte, 01 half, 10 word.
REQ-008 mem_signed  input  1  1 = sign-extend load result, 0 = zero-extend.
REQ-009 addr  input  WIDTH  effective address from ALU.
REQ-010 store_data  input  WIDTH  unaligned store source data.
REQ-011 flush  input  1  kill current or in-flight access.
REQ-012 wb_ready  input  1  write-back stage accepts the result.
REQ-013 data_req  output  1  bus request.
REQ-014 data_wr  output  1  bus request is a write.
REQ-015 data_size  output  2  bus access size, same encoding as mem_size.
REQ-016 data_addr  output  WIDTH  bus address.
REQ-017 data_wdata  output  WIDTH  lane-replicated write data.
REQ-018 data_wstrb  output  4  byte write enables.
REQ-019 data_addr_ok  input  1  bus accepted the request.
REQ-020 data_data_ok  input  1  bus completed the access; rdata valid.
REQ-021 data_rdata  input  WIDTH  raw bus read word.
REQ-022 Memdata  output  WIDTH  aligned, extended load result for write-back.
REQ-023 out_valid, stall, adel, ades  outputs  1 each  result valid; hold upstream; load address error; store address error.

Function
REQ-024 FSM states: IDLE, REQ, WAIT, HOLD.
REQ-025 IDLE: accept when in_valid & (mem_read|mem_write) & aligned & !flush: capture addr, size, signed, rd/wr, data; next state REQ.
REQ-026 REQ: data_req=1 with captured fields held stable until data_addr_ok; addr_ok without data_ok -> WAIT; addr_ok with data_ok in the same cycle -> HOLD.
REQ-027 WAIT: data_data_ok -> HOLD; otherwise remain in WAIT.
REQ-028 On completion: loads register Memdata; stores leave Memdata unchanged.
REQ-029 HOLD: out_valid=1; wb_ready -> IDLE; otherwise remain in HOLD.
REQ-030 Minimum latency from accept to out_valid is 2 cycles (addr_ok and data_ok in the first REQ cycle).
REQ-031 stall = accept-in-IDLE | state in {REQ, WAIT} | (HOLD & !wb_ready).
REQ-032 Load extraction: shift data_rdata right by 8*addr[1:0]; byte takes bits [7:0], half takes bits [15:0]; extend to WIDTH per mem_signed; word passes through unchanged.
REQ-033 Store: byte data_wdata={4{sd[7:0]}}, wstrb=0001<<addr[1:0]; half data_wdata={2{sd[15:0]}}, wstrb=0011<<addr[1:0]; word wstrb=1111. For loads, wstrb=0000.
REQ-034 Non-memory in_valid: no bus activity, stall=0, out_valid=0.
REQ-035 flush in IDLE has priority over in_valid: nothing is accepted.
REQ-036 flush in REQ: data_req stays asserted until data_addr_ok, then the discard flag is set. In WAIT with discard set, data_data_ok -> IDLE with no out_valid and Memdata unchanged.
REQ-037 flush in WAIT sets discard; flush in HOLD -> IDLE and out_valid drops next cycle.

Reset
REQ-038 resetn=0 asynchronously forces IDLE, discard=0, Memdata=0, and every output to 0.
REQ-039 Reset during REQ or WAIT abandons the access: no reissue, and a late data_ok after reset is ignored in IDLE.

Configuration
REQ-040 Macro MEM_ALIGN_CHECK_EN defined: a misaligned access (half with addr[0]=1; word with addr[1:0]!=0) is not accepted. adel (load) or ades (store) pulses for 1 cycle, there is no bus request, and the FSM stays in IDLE.
REQ-041 Macro undefined: adel=ades=0 always. Misaligned half/word addresses have their low bits forced to 0 before the request and before extraction.

Verification
REQ-042 LB addr=0x1003, signed, rdata=0x80112233, addr_ok and data_ok in the first REQ cycle -> Memdata=0xFFFFFF80, out_valid 2 cycles after accept.
REQ-043 SH addr=0x2002, store_data=0x0000ABCD -> data_wdata=0xABCDABCD, wstrb=1100, data_wr=1, size=01.
REQ-044 LW with addr_ok delayed 3 cycles and data_ok 2 cycles later -> data_req held 4 cycles with fields stable, stall high throughout, Memdata=rdata.
REQ-045 LHU accepted, flush asserted in WAIT, then data_ok -> no out_valid, Memdata unchanged, return to IDLE.
REQ-046 With MEM_ALIGN_CHECK_EN: LW addr=0x3001 -> adel=1 for 1 cycle, data_req=0; without the macro: request issued at 0x3000.
